// File: rtl/sb_msg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sb_msg_arbiter_pkg
//   Shared LTSM definitions used by the sideband message arbiter:
//   - FSM state encoding (IDLE / ISSUE / WAIT_DONE / DONE)
//   - default sideband message and lane-encoding widths
//   - requester id encoding (0 = TX sequencer, 1 = RX sequencer)
// -----------------------------------------------------------------------------
package sb_msg_arbiter_pkg;

   localparam int SB_MSG_W = 4;
   localparam int SB_ENC_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_DONE      = 2'd3
   } sb_state_e;

   typedef enum logic {
      REQ_TX = 1'b0,
      REQ_RX = 1'b1
   } sb_req_id_e;

   // The requester that should be favoured after `id` has been served.
   function automatic sb_req_id_e other_req(input sb_req_id_e id);
      return (id == REQ_TX) ? REQ_RX : REQ_TX;
   endfunction

endpackage

// File: rtl/sb_rr_arb2.sv
// -----------------------------------------------------------------------------
// sb_rr_arb2
//   Two-way round-robin grant between the TX and RX requesters.
//   The grant is combinational from the requests and the priority pointer;
//   the pointer only moves when a transaction completes (upd_i), and then
//   favours the requester that was not just served.
//
// Ports
//   clk, rst      clock, synchronous active-high reset (pointer -> TX)
//   req_tx_i      TX request
//   req_rx_i      RX request
//   upd_i         completion strobe, advances the pointer
//   upd_id_i      id of the requester that just completed
//   gnt_valid_o   at least one request present
//   gnt_id_o      id of the requester that would win this cycle
// -----------------------------------------------------------------------------
module sb_rr_arb2
   import sb_msg_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_tx_i,
   input  logic       req_rx_i,
   input  logic       upd_i,
   input  sb_req_id_e upd_id_i,
   output logic       gnt_valid_o,
   output sb_req_id_e gnt_id_o
);

   sb_req_id_e ptr_q;
   sb_req_id_e ptr_d;

   // Pointer next state: move away from the requester that just completed.
   always_comb begin
      ptr_d = ptr_q;
      if (upd_i) begin
         ptr_d = other_req(upd_id_i);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Grant selection: the pointer only matters when both requesters compete.
   always_comb begin
      gnt_valid_o = req_tx_i | req_rx_i;
      gnt_id_o    = REQ_TX;
      if (req_tx_i && req_rx_i) begin
         gnt_id_o = ptr_q;
      end else if (req_rx_i) begin
         gnt_id_o = REQ_RX;
      end else begin
         gnt_id_o = REQ_TX;
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= REQ_TX;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/sb_msg_arbiter.sv
// -----------------------------------------------------------------------------
// sb_msg_arbiter
//   Shares the LTSM sideband message channel between the TX-side and RX-side
//   sequencers of one training substate. One requester is granted at a time;
//   its message and lane encoding are latched, a one-cycle o_valid is sent,
//   and the channel is held until the sideband reports completion with a busy
//   falling edge. The winner then receives a one-cycle done pulse. If no edge
//   arrives within TIMEOUT_CYCLES of the issue cycle, the sticky o_timeout
//   flag is raised and the channel is released without a done pulse.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   i_en                             substate enable; low returns to IDLE and
//                                    clears o_timeout (pointer is kept)
//   i_valid_tx/i_msg_tx/i_enc_tx     TX request, message, lane encoding
//   i_valid_rx/i_msg_rx/i_enc_rx     RX request, message, lane encoding
//   i_busy                           sideband busy level (blocks new issue)
//   i_falling_edge_busy              sideband finished a message
//   o_valid                          one-cycle message strobe
//   o_sideband_message               latched message (0 outside ISSUE/WAIT_DONE)
//   o_sideband_data_lanes_encoding   latched encoding (0 outside ISSUE/WAIT_DONE)
//   o_done_tx / o_done_rx            one-cycle completion pulse to the winner
//   o_timeout                        sticky completion-timeout flag
// -----------------------------------------------------------------------------
module sb_msg_arbiter
   import sb_msg_arbiter_pkg::*;
#(
   parameter int MSG_W          = SB_MSG_W,
   parameter int ENC_W          = SB_ENC_W,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_valid_tx,
   input  logic [MSG_W-1:0] i_msg_tx,
   input  logic [ENC_W-1:0] i_enc_tx,
   input  logic             i_valid_rx,
   input  logic [MSG_W-1:0] i_msg_rx,
   input  logic [ENC_W-1:0] i_enc_rx,
   input  logic             i_busy,
   input  logic             i_falling_edge_busy,
   output logic             o_valid,
   output logic [MSG_W-1:0] o_sideband_message,
   output logic [ENC_W-1:0] o_sideband_data_lanes_encoding,
   output logic             o_done_tx,
   output logic             o_done_rx,
   output logic             o_timeout
);

   // The counter is 0 in the ISSUE cycle and counts the cycles since issue,
   // so it never needs to hold more than TIMEOUT_CYCLES-1.
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   sb_state_e        state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   sb_req_id_e       win_q,     win_d;
   logic [MSG_W-1:0] msg_q,     msg_d;
   logic [ENC_W-1:0] enc_q,     enc_d;
   logic             valid_q,   valid_d;
   logic             done_tx_q, done_tx_d;
   logic             done_rx_q, done_rx_d;
   logic             timeout_q, timeout_d;

   logic             gnt_valid_s;
   sb_req_id_e       gnt_id_s;
   logic             arb_upd_s;

   sb_rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_tx_i    (i_valid_tx),
      .req_rx_i    (i_valid_rx),
      .upd_i       (arb_upd_s),
      .upd_id_i    (win_q),
      .gnt_valid_o (gnt_valid_s),
      .gnt_id_o    (gnt_id_s)
   );

   // FSM next state and next values of every registered output.
   // Outputs are computed for the state being entered so that they line up
   // with that state once registered.
   always_comb begin
      state_d   = state_q;
      cnt_d     = {CNT_W{1'b0}};
      win_d     = win_q;
      msg_d     = msg_q;
      enc_d     = enc_q;
      valid_d   = 1'b0;
      done_tx_d = 1'b0;
      done_rx_d = 1'b0;
      timeout_d = timeout_q;
      arb_upd_s = 1'b0;

      if (!i_en) begin
         // Substate disabled: abandon any transaction, no done pulse.
         state_d   = ST_IDLE;
         msg_d     = {MSG_W{1'b0}};
         enc_d     = {ENC_W{1'b0}};
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               msg_d = {MSG_W{1'b0}};
               enc_d = {ENC_W{1'b0}};
               if (gnt_valid_s && !i_busy) begin
                  state_d = ST_ISSUE;
                  win_d   = gnt_id_s;
                  valid_d = 1'b1;
                  if (gnt_id_s == REQ_RX) begin
                     msg_d = i_msg_rx;
                     enc_d = i_enc_rx;
                  end else begin
                     msg_d = i_msg_tx;
                     enc_d = i_enc_tx;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end

            ST_ISSUE: begin
               // Any falling edge seen here belongs to earlier traffic.
               state_d = ST_WAIT_DONE;
               cnt_d   = cnt_q + CNT_ONE;
            end

            ST_WAIT_DONE: begin
               if (i_falling_edge_busy) begin
                  state_d = ST_DONE;
                  msg_d   = {MSG_W{1'b0}};
                  enc_d   = {ENC_W{1'b0}};
                  if (win_q == REQ_RX) begin
                     done_rx_d = 1'b1;
                  end else begin
                     done_tx_d = 1'b1;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  // Hung sideband: release the channel, keep the pointer.
                  state_d   = ST_IDLE;
                  msg_d     = {MSG_W{1'b0}};
                  enc_d     = {ENC_W{1'b0}};
                  timeout_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_DONE;
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end

            ST_DONE: begin
               state_d   = ST_IDLE;
               arb_upd_s = 1'b1;
            end

            default: begin
               state_d = ST_IDLE;
               msg_d   = {MSG_W{1'b0}};
               enc_d   = {ENC_W{1'b0}};
            end
         endcase
      end
   end

   // State, counter, latched request and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         win_q     <= REQ_TX;
         msg_q     <= {MSG_W{1'b0}};
         enc_q     <= {ENC_W{1'b0}};
         valid_q   <= 1'b0;
         done_tx_q <= 1'b0;
         done_rx_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         win_q     <= win_d;
         msg_q     <= msg_d;
         enc_q     <= enc_d;
         valid_q   <= valid_d;
         done_tx_q <= done_tx_d;
         done_rx_q <= done_rx_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_valid                        = valid_q;
   assign o_sideband_message             = msg_q;
   assign o_sideband_data_lanes_encoding = enc_q;
   assign o_done_tx                      = done_tx_q;
   assign o_done_rx                      = done_rx_q;
   assign o_timeout                      = timeout_q;

endmodule

// File: tb/tb_sb_msg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sb_msg_arbiter
//   Scenario tasks drive the arbiter; a transaction-level model (owner,
//   issue cycle, completion cycle, favoured requester) predicts every output
//   one cycle ahead. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sb_msg_arbiter;

   localparam int MSG_W = 4;
   localparam int ENC_W = 3;
   localparam int TO    = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_en = 1'b0;
   logic             i_valid_tx = 1'b0;
   logic [MSG_W-1:0] i_msg_tx = 4'h0;
   logic [ENC_W-1:0] i_enc_tx = 3'h0;
   logic             i_valid_rx = 1'b0;
   logic [MSG_W-1:0] i_msg_rx = 4'h0;
   logic [ENC_W-1:0] i_enc_rx = 3'h0;
   logic             i_busy = 1'b0;
   logic             i_falling_edge_busy = 1'b0;
   logic             o_valid;
   logic [MSG_W-1:0] o_sideband_message;
   logic [ENC_W-1:0] o_sideband_data_lanes_encoding;
   logic             o_done_tx;
   logic             o_done_rx;
   logic             o_timeout;

   always #5 clk = ~clk;

   sb_msg_arbiter #(.MSG_W(MSG_W), .ENC_W(ENC_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk                            (clk),
      .rst                            (rst),
      .i_en                           (i_en),
      .i_valid_tx                     (i_valid_tx),
      .i_msg_tx                       (i_msg_tx),
      .i_enc_tx                       (i_enc_tx),
      .i_valid_rx                     (i_valid_rx),
      .i_msg_rx                       (i_msg_rx),
      .i_enc_rx                       (i_enc_rx),
      .i_busy                         (i_busy),
      .i_falling_edge_busy            (i_falling_edge_busy),
      .o_valid                        (o_valid),
      .o_sideband_message             (o_sideband_message),
      .o_sideband_data_lanes_encoding (o_sideband_data_lanes_encoding),
      .o_done_tx                      (o_done_tx),
      .o_done_rx                      (o_done_rx),
      .o_timeout                      (o_timeout)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: who owns the channel, when it was issued, when the
   // done pulse is due, which requester is favoured, and the sticky flag.
   int               m_owner = -1;
   int               m_issue = 0;
   int               m_done  = -1;
   bit               m_fav   = 1'b0;
   bit               m_to    = 1'b0;
   logic [MSG_W-1:0] m_msg   = 4'h0;
   logic [ENC_W-1:0] m_enc   = 3'h0;
   logic [10:0]      exp_v   = 11'h0;

   function automatic logic [10:0] dut_v();
      return {o_valid, o_sideband_message, o_sideband_data_lanes_encoding,
              o_done_tx, o_done_rx, o_timeout};
   endfunction

   // Consume the inputs of cycle `cyc` and predict the outputs of cyc+1.
   task automatic model_step();
      int w;
      bit active;
      if (rst) begin
         m_owner = -1; m_done = -1; m_fav = 1'b0; m_to = 1'b0;
      end else if (!i_en) begin
         m_owner = -1; m_done = -1; m_to = 1'b0;
      end else if (m_owner < 0) begin
         if (!i_busy && (i_valid_tx || i_valid_rx)) begin
            if (i_valid_tx && i_valid_rx) w = m_fav ? 1 : 0;
            else                          w = i_valid_rx ? 1 : 0;
            m_owner = w;
            m_issue = cyc + 1;
            m_done  = -1;
            m_msg   = (w == 1) ? i_msg_rx : i_msg_tx;
            m_enc   = (w == 1) ? i_enc_rx : i_enc_tx;
         end
      end else if (m_done >= 0) begin
         m_fav   = (m_owner == 0);
         m_owner = -1;
         m_done  = -1;
      end else if (cyc > m_issue) begin
         if (i_falling_edge_busy) m_done = cyc + 1;
         else if (cyc == m_issue + TO - 1) begin
            m_to    = 1'b1;
            m_owner = -1;
         end
      end
      active = (m_owner >= 0) && (m_done < 0);
      exp_v = {(m_owner >= 0 && m_issue == cyc + 1),
               active ? m_msg : 4'h0,
               active ? m_enc : 3'h0,
               (m_done == cyc + 1 && m_owner == 0),
               (m_done == cyc + 1 && m_owner == 1),
               m_to};
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; i_en = 1'b0;
      step(); step();
      n_checks++;
      if (dut_v() !== 11'h000) $display("FAIL reset_values got=%03h exp=000", dut_v());
      else n_pass++;
      rst = 1'b0; i_en = 1'b1;
      step();
      n_checks++;
      if (dut_v() !== exp_v) $display("FAIL reset_release cyc=%0d got=%03h exp=%03h", cyc, dut_v(), exp_v);
      else n_pass++;
   endtask

   task automatic test_single_tx();
      bit seen = 1'b0;
      int extra = 0;
      i_valid_tx = 1'b1; i_msg_tx = 4'h3; i_enc_tx = 3'b101;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         n_checks++;
         if (dut_v() !== exp_v) $display("FAIL single_tx cyc=%0d got=%03h exp=%03h", cyc, dut_v(), exp_v);
         else n_pass++;
         if (o_valid) seen = 1'b1;
      end
      n_checks++;
      if (!seen || o_sideband_message !== 4'h3 || o_sideband_data_lanes_encoding !== 3'b101)
         $display("FAIL single_tx_issue got=%0b/%h/%b exp=1/3/101", seen, o_sideband_message, o_sideband_data_lanes_encoding);
      else n_pass++;
      i_msg_tx = 4'hC; i_enc_tx = 3'b010;
      for (int k = 0; k < 5; k++) begin
         step();
         n_checks++;
         if (dut_v() !== exp_v) $display("FAIL single_tx_wait cyc=%0d got=%03h exp=%03h", cyc, dut_v(), exp_v);
         else n_pass++;
         if (o_valid) extra++;
      end
      n_checks++;
      if (extra != 0 || o_sideband_message !== 4'h3 || o_sideband_data_lanes_encoding !== 3'b101)
         $display("FAIL single_tx_hold got=%0d/%h/%b exp=0/3/101", extra, o_sideband_message, o_sideband_data_lanes_encoding);
      else n_pass++;
      i_falling_edge_busy = 1'b1;
      step();
      i_falling_edge_busy = 1'b0;
      n_checks++;
      if (o_done_tx !== 1'b1 || o_done_rx !== 1'b0 || o_sideband_message !== 4'h0)
         $display("FAIL single_tx_done got=%b%b/%h exp=10/0", o_done_tx, o_done_rx, o_sideband_message);
      else n_pass++;
      i_valid_tx = 1'b0;
      step();
      n_checks++;
      if (dut_v() !== 11'h000) $display("FAIL single_tx_idle got=%03h exp=000", dut_v());
      else n_pass++;
   endtask

   task automatic test_alternate();
      int order[$];
      int since = -1;
      rst = 1'b1;
      i_valid_tx = 1'b1; i_msg_tx = 4'h1; i_enc_tx = 3'b001;
      i_valid_rx = 1'b1; i_msg_rx = 4'h2; i_enc_rx = 3'b010;
      step();
      rst = 1'b0;
      for (int k = 0; k < 40 && order.size() < 3; k++) begin
         step();
         n_checks++;
         if (dut_v() !== exp_v) $display("FAIL alternate cyc=%0d got=%03h exp=%03h", cyc, dut_v(), exp_v);
         else n_pass++;
         if (o_done_tx) order.push_back(0);
         if (o_done_rx) order.push_back(1);
         if (o_valid) since = 0;
         else if (since >= 0) since++;
         i_falling_edge_busy = (since == 2);
         if (since == 2) since = -1;
      end
      i_valid_tx = 1'b0; i_valid_rx = 1'b0; i_falling_edge_busy = 1'b0;
      n_checks++;
      if (order.size() != 3) $display("FAIL alternate_count got=%0d exp=3", order.size());
      else if (order[0] != 0 || order[1] != 1 || order[2] != 0)
         $display("FAIL alternate_order got=%0d%0d%0d exp=010", order[0], order[1], order[2]);
      else n_pass++;
      step();
   endtask

   task automatic test_busy();
      int issued = 0;
      i_busy = 1'b1;
      i_valid_rx = 1'b1; i_msg_rx = 4'h9; i_enc_rx = 3'b011;
      for (int k = 0; k < 5; k++) begin
         step();
         n_checks++;
         if (dut_v() !== exp_v) $display("FAIL busy_hold cyc=%0d got=%03h exp=%03h", cyc, dut_v(), exp_v);
         else n_pass++;
         if (o_valid) issued++;
      end
      i_busy = 1'b0;
      step();
      n_checks++;
      if (issued != 0 || o_valid !== 1'b1 || o_sideband_message !== 4'h9)
         $display("FAIL busy_release got=%0d/%b/%h exp=0/1/9", issued, o_valid, o_sideband_message);
      else n_pass++;
      step();
      i_falling_edge_busy = 1'b1;
      step();
      i_falling_edge_busy = 1'b0;
      n_checks++;
      if (o_done_rx !== 1'b1 || o_done_tx !== 1'b0) $display("FAIL busy_done got=%b%b exp=01", o_done_tx, o_done_rx);
      else n_pass++;
      i_valid_rx = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      bit seen = 1'b0;
      i_valid_tx = 1'b1; i_msg_tx = 4'h5; i_enc_tx = 3'b110;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         if (o_valid) seen = 1'b1;
      end
      n_checks++;
      if (!seen) $display("FAIL timeout_issue got=0 exp=1");
      else n_pass++;
      i_valid_tx = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         step();
         n_checks++;
         if (o_timeout !== (k == TO) || o_done_tx !== 1'b0 || dut_v() !== exp_v)
            $display("FAIL timeout_cnt k=%0d got=%b/%03h exp=%b/%03h", k, o_timeout, dut_v(), (k == TO), exp_v);
         else n_pass++;
      end
      i_valid_rx = 1'b1; i_msg_rx = 4'hA; i_enc_rx = 3'b100;
      step();
      n_checks++;
      if (o_valid !== 1'b1 || o_sideband_message !== 4'hA || o_timeout !== 1'b1)
         $display("FAIL timeout_reissue got=%b/%h/%b exp=1/a/1", o_valid, o_sideband_message, o_timeout);
      else n_pass++;
      step();
      i_falling_edge_busy = 1'b1;
      step();
      i_falling_edge_busy = 1'b0;
      i_valid_rx = 1'b0;
      n_checks++;
      if (o_done_rx !== 1'b1 || o_timeout !== 1'b1) $display("FAIL timeout_sticky got=%b/%b exp=1/1", o_done_rx, o_timeout);
      else n_pass++;
      i_en = 1'b0;
      step();
      n_checks++;
      if (dut_v() !== 11'h000) $display("FAIL timeout_clear got=%03h exp=000", dut_v());
      else n_pass++;
      i_en = 1'b1;
      step();
   endtask

   task automatic test_fe_on_issue();
      bit seen = 1'b0;
      i_valid_tx = 1'b1; i_msg_tx = 4'h7; i_enc_tx = 3'b001;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         if (o_valid) seen = 1'b1;
      end
      i_falling_edge_busy = 1'b1;
      step();
      i_falling_edge_busy = 1'b0;
      n_checks++;
      if (!seen || o_done_tx !== 1'b0 || o_sideband_message !== 4'h7 || dut_v() !== exp_v)
         $display("FAIL fe_on_issue got=%0b/%03h exp=1/%03h", seen, dut_v(), exp_v);
      else n_pass++;
      step();
      i_falling_edge_busy = 1'b1;
      step();
      i_falling_edge_busy = 1'b0;
      n_checks++;
      if (o_done_tx !== 1'b1) $display("FAIL fe_late_done got=%b exp=1", o_done_tx);
      else n_pass++;
      i_valid_tx = 1'b0;
      step();
   endtask

   task automatic test_en_drop();
      bit seen = 1'b0;
      i_valid_rx = 1'b1; i_msg_rx = 4'hE; i_enc_rx = 3'b111;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         if (o_valid) seen = 1'b1;
      end
      step(); step();
      i_en = 1'b0;
      step();
      n_checks++;
      if (!seen || dut_v() !== 11'h000) $display("FAIL en_drop got=%0b/%03h exp=1/000", seen, dut_v());
      else n_pass++;
      i_falling_edge_busy = 1'b1;
      step();
      i_falling_edge_busy = 1'b0;
      n_checks++;
      if (dut_v() !== 11'h000) $display("FAIL en_drop_nodone got=%03h exp=000", dut_v());
      else n_pass++;
      i_en = 1'b1; i_valid_rx = 1'b0;
      step();
   endtask

   task automatic test_rst_mid();
      // Serve TX once so the pointer favours RX before the reset.
      i_valid_tx = 1'b1; i_msg_tx = 4'h4; i_enc_tx = 3'b000;
      step(); step(); step();
      i_falling_edge_busy = 1'b1;
      step();
      i_falling_edge_busy = 1'b0;
      i_msg_tx = 4'hA; i_enc_tx = 3'b010;
      i_valid_rx = 1'b1; i_msg_rx = 4'hB; i_enc_rx = 3'b011;
      step(); step();
      n_checks++;
      if (o_valid !== 1'b1 || o_sideband_message !== 4'hB) $display("FAIL rst_mid_rxwin got=%b/%h exp=1/b", o_valid, o_sideband_message);
      else n_pass++;
      step();
      rst = 1'b1;
      step();
      n_checks++;
      if (dut_v() !== 11'h000) $display("FAIL rst_mid_values got=%03h exp=000", dut_v());
      else n_pass++;
      rst = 1'b0;
      step();
      n_checks++;
      if (o_valid !== 1'b1 || o_sideband_message !== 4'hA || dut_v() !== exp_v)
         $display("FAIL rst_mid_ptr got=%03h exp=%03h", dut_v(), exp_v);
      else n_pass++;
      step();
      i_falling_edge_busy = 1'b1;
      step();
      i_falling_edge_busy = 1'b0;
      i_valid_tx = 1'b0; i_valid_rx = 1'b0;
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 299) == 0);
         i_en = ($urandom_range(0, 99) != 0);
         i_busy = ($urandom_range(0, 3) == 0);
         i_falling_edge_busy = ($urandom_range(0, 4) == 0);
         if (!i_valid_tx) i_valid_tx = ($urandom_range(0, 2) == 0);
         else if ($urandom_range(0, 49) == 0) i_valid_tx = 1'b0;
         if (!i_valid_rx) i_valid_rx = ($urandom_range(0, 2) == 0);
         else if ($urandom_range(0, 49) == 0) i_valid_rx = 1'b0;
         i_msg_tx = 4'($urandom); i_enc_tx = 3'($urandom);
         i_msg_rx = 4'($urandom); i_enc_rx = 3'($urandom);
         step();
         n_checks++;
         if (dut_v() !== exp_v) $display("FAIL random cyc=%0d got=%03h exp=%03h", cyc, dut_v(), exp_v);
         else n_pass++;
         if (o_done_tx) i_valid_tx = 1'b0;
         if (o_done_rx) i_valid_rx = 1'b0;
      end
      rst = 1'b0; i_en = 1'b1; i_busy = 1'b0; i_falling_edge_busy = 1'b0;
      i_valid_tx = 1'b0; i_valid_rx = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_alternate();
      test_busy();
      test_timeout();
      test_fe_on_issue();
      test_en_drop();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
